bar2_rd_completer: RTL and testbench
====================================

BAR2_RD_COMPLETER -- requirements
Module: bar2_rd_completer

Interface
REQ-001 The block SHALL have no parameters; the completer ID is a port.
REQ-002 trn_clk  in  1  single clock for all logic.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 trn_rd/trn_rrem_n/trn_rsof_n/trn_reof_n/trn_rsrc_rdy_n/trn_rdst_rdy_n  in  64/8/1/1/1/1  TRN RX stream, monitored only.
REQ-005 trn_rbar_hit_n  in  7  BAR hit; bit 2 low selects this block.
REQ-006 interrupts_enabled  in  1  live enable flag from the interrupt config block.
REQ-007 interrupt_period  in  32  live period register.
REQ-008 completer_id  in  16  {bus, device, function}.
REQ-009 cpl_req  out  1  TX arbiter request; cpl_gnt  in  1  grant.
REQ-010 trn_td/trn_trem_n/trn_tsof_n/trn_teof_n/trn_tsrc_rdy_n/trn_tsrc_dsc_n  out  64/8/1/1/1/1  TRN TX stream.
REQ-011 trn_tdst_rdy_n  in  1  TX sink ready.
REQ-012 cpl_overflow  out  1  sticky flag: a read was dropped.

Function
REQ-013 RX beat valid = !trn_rsrc_rdy_n && !trn_rdst_rdy_n; TX beat accepted = !trn_tsrc_rdy_n && !trn_tdst_rdy_n.
REQ-014 RX FSM R_IDLE: valid beat with !trn_rsof_n, !trn_rbar_hit_n[2], trn_rd[62:56]=7'b0000000 (MRd32), length trn_rd[41:32]=1 -> capture TC, attr, requester ID trn_rd[31:16], tag trn_rd[15:8], go R_ADDR; any other SOF -> stay R_IDLE.
REQ-015 R_ADDR: next valid beat captures offset trn_rd[39:34] and lower address trn_rd[38:32], pushes entry, returns to R_IDLE.
REQ-016 Entry store SHALL be a 2-deep FIFO; push when full drops the request and sets cpl_overflow.
REQ-017 Readback: offset 6'b001000 -> {31'b0, interrupts_enabled}; 6'b001010 -> {interrupt_period[29:0], 2'b00}; all other offsets -> 32'h0.
REQ-018 Readback SHALL be byte-swapped (byte0<->byte3, byte1<->byte2) onto trn_td[31:0] and sampled on the cycle QW1 is first presented.
REQ-019 TX FSM T_IDLE: FIFO non-empty -> cpl_req=1, go T_REQ.
REQ-020 T_REQ: cpl_gnt=1 -> go T_QW0, present QW0 next cycle.
REQ-021 T_QW0: trn_tsof_n=0, trn_teof_n=1, trn_trem_n=8'h00; trn_td[63:32]={1'b0, 2'b10, 5'b01010, 1'b0, TC, 4'b0, 1'b0, 1'b0, attr, 2'b0, 10'd1}; trn_td[31:0]={completer_id, 3'b000, 1'b0, 12'd4}; hold until accepted, then T_QW1.
REQ-022 T_QW1: trn_tsof_n=1, trn_teof_n=0, trn_trem_n=8'h00; trn_td[63:32]={requester ID, tag, 1'b0, lower address}; trn_td[31:0]=data; on accept pop FIFO, drop cpl_req, go T_IDLE.
REQ-023 trn_tsrc_rdy_n SHALL be low only in T_QW0/T_QW1; outputs SHALL hold stable while stalled; trn_tsrc_dsc_n SHALL be constant 1.
REQ-024 Simultaneous push and pop SHALL both occur; a push to a full FIFO coinciding with a pop SHALL be accepted.
REQ-025 Latency: entry visible the cycle after R_ADDR beat; with cpl_gnt tied high and no stall, QW0 SHALL appear 2 cycles after that.

Reset
REQ-026 On reset_n low, asynchronously: RX FSM R_IDLE, TX FSM T_IDLE, FIFO empty, cpl_req=0, cpl_overflow=0, trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_tsrc_dsc_n=1, trn_td=0, trn_trem_n=8'h00.
REQ-027 Reset mid-TLP SHALL abort without completing; partially received requests SHALL be discarded.

Configuration
REQ-028 Macro BAR2_RD64_EN: when defined, R_IDLE SHALL also accept MRd64 (trn_rd[62:56]=7'b0100000), taking the offset from trn_rd[7:2] and lower address from trn_rd[6:0] of the next beat; when undefined, MRd64 SHALL be ignored.

Verification
REQ-029 MRd32 BAR2 offset 0x28, tag 0x05, period=0x3D090, cpl_gnt=1 -> CplD length 1, byte count 4, tag 0x05, lower addr 0x28, data 32'h40_42_0F_00.
REQ-030 MRd32 offset 0x20 with interrupts_enabled=1 -> data 32'h01000000; offset 0x30 -> data 0.
REQ-031 Three back-to-back reads with cpl_gnt=0 -> first two completed in order after grant, third dropped, cpl_overflow=1.
REQ-032 trn_tdst_rdy_n toggled every cycle during completion -> both beats held stable, exactly one SOF and one EOF emitted.
REQ-033 MRd64 BAR2 offset 0x28 -> completion with BAR2_RD64_EN defined, no TX activity without it; MRd32 on BAR0 or length 2 -> no completion.
REQ-034 reset_n low during T_QW1 -> trn_tsrc_rdy_n=1 immediately, FIFO empty, no completion after release.

Source files
------------

// File: rtl/bar2_rd_completer.sv
// rtl/bar2_rd_completer.sv - BAR2 single-dword memory-read completer
//
// Purpose: watches the TRN RX stream for single-dword memory reads that hit
// BAR2, queues up to two of them, and answers each with a two-beat CplD on
// the TRN TX stream after winning the TX arbiter. The readback exposes the
// interrupt enable flag and interrupt period register.
//
// Configuration: define BAR2_RD64_EN to also accept 64-bit address MRd.
//
// Ports:
//   trn_clk, reset_n              clock, asynchronous active-low reset
//   trn_rd .. trn_rdst_rdy_n      TRN RX stream (monitored only)
//   trn_rbar_hit_n                BAR hit vector, bit 2 low selects this block
//   interrupts_enabled            live interrupt enable flag
//   interrupt_period              live interrupt period register
//   completer_id                  {bus, device, function} for the CplD header
//   cpl_req / cpl_gnt             TX arbiter request / grant
//   trn_td .. trn_tsrc_dsc_n      TRN TX stream driven by this block
//   trn_tdst_rdy_n                TX sink ready
//   cpl_overflow                  sticky, set when a read had to be dropped
module bar2_rd_completer (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] trn_rd,
  input  logic [7:0]  trn_rrem_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rdst_rdy_n,
  input  logic [6:0]  trn_rbar_hit_n,
  input  logic        interrupts_enabled,
  input  logic [31:0] interrupt_period,
  input  logic [15:0] completer_id,
  output logic        cpl_req,
  input  logic        cpl_gnt,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n,
  output logic        cpl_overflow
);

  typedef struct packed {
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [5:0]  offset;
    logic [6:0]  lower;
  } entry_t;

  typedef enum logic { R_IDLE, R_ADDR } rx_state_t;
  typedef enum logic [1:0] { T_IDLE, T_REQ, T_QW0, T_QW1 } tx_state_t;

  // Only part of the RX beat matters; the rest is folded away here.
  logic unused_inputs;
  assign unused_inputs = ^{trn_rrem_n, trn_reof_n, trn_rd, trn_rbar_hit_n,
                           interrupt_period[31:30]};

  // ---------------- RX request decode ----------------
  rx_state_t   rx_state, rx_state_nxt;
  logic        rx_valid, rx_is_mrd32, rx_is_mrd64, hdr_ok, push;
  logic [2:0]  hdr_tc;
  logic [1:0]  hdr_attr;
  logic [15:0] hdr_req_id;
  logic [7:0]  hdr_tag;
  entry_t      push_entry;

  assign rx_valid    = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign rx_is_mrd32 = (trn_rd[62:56] == 7'b0000000);
`ifdef BAR2_RD64_EN
  logic hdr_is64;
  assign rx_is_mrd64 = (trn_rd[62:56] == 7'b0100000);
`else
  assign rx_is_mrd64 = 1'b0;
`endif
  assign hdr_ok = rx_valid && !trn_rsof_n && !trn_rbar_hit_n[2] &&
                  (rx_is_mrd32 || rx_is_mrd64) && (trn_rd[41:32] == 10'd1);

  always_comb begin
    rx_state_nxt = rx_state;
    push         = 1'b0;
    case (rx_state)
      R_IDLE: if (hdr_ok) rx_state_nxt = R_ADDR;
      R_ADDR: if (rx_valid) begin
        push         = 1'b1;
        rx_state_nxt = R_IDLE;
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    push_entry.tc     = hdr_tc;
    push_entry.attr   = hdr_attr;
    push_entry.req_id = hdr_req_id;
    push_entry.tag    = hdr_tag;
    push_entry.offset = trn_rd[39:34];
    push_entry.lower  = trn_rd[38:32];
`ifdef BAR2_RD64_EN
    // A 4DW header puts the low address dword in the lower half of beat 2.
    if (hdr_is64) begin
      push_entry.offset = trn_rd[7:2];
      push_entry.lower  = trn_rd[6:0];
    end
`endif
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= R_IDLE;
      hdr_tc     <= 3'd0;
      hdr_attr   <= 2'd0;
      hdr_req_id <= 16'd0;
      hdr_tag    <= 8'd0;
`ifdef BAR2_RD64_EN
      hdr_is64   <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == R_IDLE && hdr_ok) begin
        hdr_tc     <= trn_rd[54:52];
        hdr_attr   <= trn_rd[45:44];
        hdr_req_id <= trn_rd[31:16];
        hdr_tag    <= trn_rd[15:8];
`ifdef BAR2_RD64_EN
        hdr_is64   <= rx_is_mrd64;
`endif
      end
    end
  end

  // ---------------- 2-deep request FIFO ----------------
  entry_t     fifo_mem [2];
  logic       wr_ptr, rd_ptr, pop, push_ok, fifo_empty, fifo_full;
  logic [1:0] fifo_cnt;
  entry_t     head;

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign fifo_full  = (fifo_cnt == 2'd2);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = push && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge trn_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
      cpl_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && !push_ok) cpl_overflow <= 1'b1;
    end
  end

  // ---------------- TX completion ----------------
  tx_state_t   tx_state, tx_state_nxt;
  logic        tx_accept, req_nxt, sof_nxt, eof_nxt, rdy_nxt;
  logic [63:0] td_nxt, qw0, qw1;
  logic [31:0] readback;

  assign tx_accept = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;

  always_comb begin
    case (head.offset)
      6'b001000: readback = {31'b0, interrupts_enabled};
      6'b001010: readback = {interrupt_period[29:0], 2'b00};
      default:   readback = 32'h0;
    endcase
  end

  assign qw0 = {1'b0, 2'b10, 5'b01010, 1'b0, head.tc, 4'b0, 1'b0, 1'b0,
                head.attr, 2'b0, 10'd1,
                completer_id, 3'b000, 1'b0, 12'd4};
  // Payload goes out byte-swapped: the link is little-endian per dword.
  assign qw1 = {head.req_id, head.tag, 1'b0, head.lower,
                readback[7:0], readback[15:8], readback[23:16], readback[31:24]};

  always_comb begin
    tx_state_nxt = tx_state;
    req_nxt      = cpl_req;
    td_nxt       = trn_td;
    sof_nxt      = trn_tsof_n;
    eof_nxt      = trn_teof_n;
    rdy_nxt      = trn_tsrc_rdy_n;
    pop          = 1'b0;
    case (tx_state)
      T_IDLE: if (!fifo_empty) begin
        req_nxt      = 1'b1;
        tx_state_nxt = T_REQ;
      end
      T_REQ: if (cpl_gnt) begin
        tx_state_nxt = T_QW0;
        td_nxt       = qw0;
        sof_nxt      = 1'b0;
        eof_nxt      = 1'b1;
        rdy_nxt      = 1'b0;
      end
      T_QW0: if (tx_accept) begin
        tx_state_nxt = T_QW1;
        td_nxt       = qw1;
        sof_nxt      = 1'b1;
        eof_nxt      = 1'b0;
      end
      T_QW1: if (tx_accept) begin
        tx_state_nxt = T_IDLE;
        pop          = 1'b1;
        req_nxt      = 1'b0;
        td_nxt       = 64'h0;
        eof_nxt      = 1'b1;
        rdy_nxt      = 1'b1;
      end
      default: tx_state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state       <= T_IDLE;
      cpl_req        <= 1'b0;
      trn_td         <= 64'h0;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_tsrc_rdy_n <= 1'b1;
    end else begin
      tx_state       <= tx_state_nxt;
      cpl_req        <= req_nxt;
      trn_td         <= td_nxt;
      trn_tsof_n     <= sof_nxt;
      trn_teof_n     <= eof_nxt;
      trn_tsrc_rdy_n <= rdy_nxt;
    end
  end

  assign trn_trem_n     = 8'h00;
  assign trn_tsrc_dsc_n = 1'b1;

endmodule

// File: tb/tb_bar2_rd_completer.sv
// tb/tb_bar2_rd_completer.sv - directed bench for bar2_rd_completer
module tb_bar2_rd_completer;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] trn_rd = 64'h0;
  logic [7:0]  trn_rrem_n = 8'h0;
  logic        trn_rsof_n = 1'b1;
  logic        trn_reof_n = 1'b1;
  logic        trn_rsrc_rdy_n = 1'b1;
  logic        trn_rdst_rdy_n = 1'b0;
  logic [6:0]  trn_rbar_hit_n = 7'h7F;
  logic        interrupts_enabled = 1'b0;
  logic [31:0] interrupt_period = 32'h0;
  logic [15:0] completer_id = 16'h0100;
  logic        cpl_req;
  logic        cpl_gnt = 1'b0;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n = 1'b0;
  logic        cpl_overflow;

  localparam logic [6:0] BAR2 = 7'b1111011;
  localparam logic [6:0] BAR0 = 7'b1111110;

  bar2_rd_completer dut (
    .trn_clk(trn_clk), .reset_n(reset_n),
    .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n),
    .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_rbar_hit_n(trn_rbar_hit_n),
    .interrupts_enabled(interrupts_enabled), .interrupt_period(interrupt_period),
    .completer_id(completer_id), .cpl_req(cpl_req), .cpl_gnt(cpl_gnt),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .cpl_overflow(cpl_overflow)
  );

  always #5 trn_clk = ~trn_clk;

  // TX sink behaviour: 0 always ready, 1 toggles, 2 accepts QW0 only.
  int tdst_mode = 0;
  always @(posedge trn_clk) begin
    #1;
    case (tdst_mode)
      0:       trn_tdst_rdy_n = 1'b0;
      1:       trn_tdst_rdy_n = ~trn_tdst_rdy_n;
      default: trn_tdst_rdy_n = trn_tsof_n;
    endcase
  end

  // TX monitor: records accepted beats and checks hold-while-stalled.
  logic [63:0] cap_q[$];
  int          sof_cnt = 0, eof_cnt = 0, stall_seen = 0, stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_td = 64'h0;
  logic        prev_sof = 1'b1, prev_eof = 1'b1;
  always @(negedge trn_clk) begin
    if (prev_stall && reset_n) begin
      stall_seen++;
      if (trn_tsrc_rdy_n || trn_td !== prev_td || trn_tsof_n !== prev_sof ||
          trn_teof_n !== prev_eof) stall_err++;
    end
    prev_stall = !trn_tsrc_rdy_n && trn_tdst_rdy_n && reset_n;
    prev_td    = trn_td;
    prev_sof   = trn_tsof_n;
    prev_eof   = trn_teof_n;
    if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
      cap_q.push_back(trn_td);
      if (!trn_tsof_n) sof_cnt++;
      if (!trn_teof_n) eof_cnt++;
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic rx_beat(input logic [63:0] d, input logic sof, input logic eof,
                         input logic [6:0] bar);
    @(posedge trn_clk); #1;
    trn_rd = d; trn_rsof_n = ~sof; trn_reof_n = ~eof;
    trn_rbar_hit_n = bar; trn_rsrc_rdy_n = 1'b0;
  endtask

  task automatic rx_idle();
    @(posedge trn_clk); #1;
    trn_rsrc_rdy_n = 1'b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b1;
    trn_rbar_hit_n = 7'h7F;
  endtask

  task automatic send_mrd(input logic is64, input logic [6:0] bar, input logic [9:0] len,
                          input logic [2:0] tc, input logic [1:0] attr,
                          input logic [15:0] rid, input logic [7:0] tag,
                          input logic [31:0] addr);
    logic [31:0] dw0;
    dw0 = {1'b0, (is64 ? 7'b0100000 : 7'b0000000), 1'b0, tc, 4'b0, 2'b0, attr, 2'b0, len};
    rx_beat({dw0, rid, tag, 8'h0F}, 1'b1, 1'b0, bar);
    if (is64) rx_beat({32'h0, addr}, 1'b0, 1'b1, bar);
    else      rx_beat({addr, 32'h0}, 1'b0, 1'b1, bar);
  endtask

  task automatic wait_caps(input int n, input int limit);
    int k;
    k = 0;
    while (cap_q.size() < n && k < limit) begin
      @(negedge trn_clk);
      k++;
    end
    @(negedge trn_clk);
  endtask

  int base, lat, s0, e0, se0, ss0, reached;

  initial begin
    // Reset state
    repeat (3) @(negedge trn_clk);
    check("rst_src_rdy", 64'(trn_tsrc_rdy_n), 64'd1);
    check("rst_sof", 64'(trn_tsof_n), 64'd1);
    check("rst_eof", 64'(trn_teof_n), 64'd1);
    check("rst_dsc", 64'(trn_tsrc_dsc_n), 64'd1);
    check("rst_td", trn_td, 64'h0);
    check("rst_trem", 64'(trn_trem_n), 64'h0);
    check("rst_req", 64'(cpl_req), 64'd0);
    check("rst_ovf", 64'(cpl_overflow), 64'd0);
    @(posedge trn_clk); #1;
    reset_n = 1'b1;

    // Period readback at 0x28, plus QW0 latency
    interrupt_period = 32'h0003_D090;
    cpl_gnt = 1'b1;
    base = cap_q.size();
    send_mrd(1'b0, BAR2, 10'd1, 3'd0, 2'd0, 16'hABCD, 8'h05, 32'hF000_0028);
    rx_idle();
    lat = 0;
    while (lat < 20) begin
      @(negedge trn_clk);
      if (!trn_tsrc_rdy_n && !trn_tsof_n) break;
      lat++;
    end
    check("qw0_latency", 64'(lat), 64'd2);
    wait_caps(base + 2, 20);
    check("t1_count", 64'(cap_q.size()), 64'(base + 2));
    check("t1_qw0", cap_q[base], 64'h4A000001_01000004);
    check("t1_qw1", cap_q[base + 1], 64'hABCD0528_40420F00);
    repeat (2) @(negedge trn_clk);
    check("t1_req_drop", 64'(cpl_req), 64'd0);

    // Enable readback at 0x20 with nonzero TC/attr
    interrupts_enabled = 1'b1;
    base = cap_q.size();
    send_mrd(1'b0, BAR2, 10'd1, 3'b101, 2'b10, 16'h1234, 8'h7E, 32'h0000_0020);
    rx_idle();
    wait_caps(base + 2, 20);
    check("t2_qw0", cap_q[base], 64'h4A502001_01000004);
    check("t2_qw1", cap_q[base + 1], 64'h12347E20_01000000);

    // Unmapped offset 0x30 reads zero
    base = cap_q.size();
    send_mrd(1'b0, BAR2, 10'd1, 3'd0, 2'd0, 16'h0001, 8'h11, 32'h8000_0030);
    rx_idle();
    wait_caps(base + 2, 20);
    check("t3_qw0", cap_q[base], 64'h4A000001_01000004);
    check("t3_qw1", cap_q[base + 1], 64'h00011130_00000000);

    // Three back-to-back reads without grant: third dropped
    cpl_gnt = 1'b0;
    base = cap_q.size();
    send_mrd(1'b0, BAR2, 10'd1, 3'd0, 2'd0, 16'h0A0A, 8'h01, 32'h0000_0028);
    send_mrd(1'b0, BAR2, 10'd1, 3'd0, 2'd0, 16'h0B0B, 8'h02, 32'h0000_0020);
    send_mrd(1'b0, BAR2, 10'd1, 3'd0, 2'd0, 16'h0C0C, 8'h03, 32'h0000_0028);
    rx_idle();
    repeat (3) @(negedge trn_clk);
    check("t4_ovf", 64'(cpl_overflow), 64'd1);
    check("t4_req", 64'(cpl_req), 64'd1);
    check("t4_no_tx", 64'(cap_q.size()), 64'(base));
    cpl_gnt = 1'b1;
    wait_caps(base + 4, 40);
    repeat (10) @(negedge trn_clk);
    check("t4_count", 64'(cap_q.size()), 64'(base + 4));
    check("t4_a_qw1", cap_q[base + 1], 64'h0A0A0128_40420F00);
    check("t4_b_qw1", cap_q[base + 3], 64'h0B0B0220_01000000);
    check("t4_ovf_sticky", 64'(cpl_overflow), 64'd1);

    // Sink toggles ready every cycle
    tdst_mode = 1;
    base = cap_q.size(); s0 = sof_cnt; e0 = eof_cnt; se0 = stall_err; ss0 = stall_seen;
    send_mrd(1'b0, BAR2, 10'd1, 3'd0, 2'd0, 16'h5555, 8'h20, 32'h0000_0028);
    rx_idle();
    wait_caps(base + 2, 40);
    repeat (6) @(negedge trn_clk);
    check("t5_count", 64'(cap_q.size()), 64'(base + 2));
    check("t5_sof", 64'(sof_cnt - s0), 64'd1);
    check("t5_eof", 64'(eof_cnt - e0), 64'd1);
    check("t5_stall_seen", 64'(stall_seen > ss0), 64'd1);
    check("t5_stable", 64'(stall_err - se0), 64'd0);
    check("t5_qw0", cap_q[base], 64'h4A000001_01000004);
    check("t5_qw1", cap_q[base + 1], 64'h55552028_40420F00);
    tdst_mode = 0;
    repeat (2) @(negedge trn_clk);

    // MRd64 at offset 0x28
    base = cap_q.size();
    send_mrd(1'b1, BAR2, 10'd1, 3'd0, 2'd0, 16'h6464, 8'h40, 32'h0000_0028);
    rx_idle();
    repeat (15) @(negedge trn_clk);
`ifdef BAR2_RD64_EN
    check("t6_rd64_count", 64'(cap_q.size()), 64'(base + 2));
    check("t6_rd64_qw1", cap_q[base + 1], 64'h64644028_40420F00);
`else
    check("t6_rd64_ignored", 64'(cap_q.size()), 64'(base));
    check("t6_rd64_req", 64'(cpl_req), 64'd0);
`endif

    // BAR0 hit and length 2 are ignored
    base = cap_q.size();
    send_mrd(1'b0, BAR0, 10'd1, 3'd0, 2'd0, 16'h7777, 8'h50, 32'h0000_0028);
    send_mrd(1'b0, BAR2, 10'd2, 3'd0, 2'd0, 16'h7777, 8'h51, 32'h0000_0028);
    rx_idle();
    repeat (15) @(negedge trn_clk);
    check("t6_ignored", 64'(cap_q.size()), 64'(base));
    check("t6_req", 64'(cpl_req), 64'd0);

    // Reset while QW1 is stalled on the link
    tdst_mode = 2;
    send_mrd(1'b0, BAR2, 10'd1, 3'd0, 2'd0, 16'h8888, 8'h60, 32'h0000_0020);
    rx_idle();
    reached = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge trn_clk);
      if (!trn_tsrc_rdy_n && !trn_teof_n) begin
        reached = 1;
        break;
      end
    end
    check("t7_qw1_reached", 64'(reached), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t7_src_rdy", 64'(trn_tsrc_rdy_n), 64'd1);
    check("t7_eof", 64'(trn_teof_n), 64'd1);
    check("t7_td", trn_td, 64'h0);
    check("t7_req", 64'(cpl_req), 64'd0);
    check("t7_ovf_clr", 64'(cpl_overflow), 64'd0);
    @(posedge trn_clk); #1;
    reset_n = 1'b1;
    tdst_mode = 0;
    base = cap_q.size();
    repeat (20) @(negedge trn_clk);
    check("t7_no_cpl", 64'(cap_q.size()), 64'(base));
    check("t7_idle_req", 64'(cpl_req), 64'd0);

    // Reset between header and address beat discards the request
    base = cap_q.size();
    rx_beat({1'b0, 7'b0000000, 1'b0, 3'd0, 4'b0, 2'b0, 2'd0, 2'b0, 10'd1,
             16'h9999, 8'h70, 8'h0F}, 1'b1, 1'b0, BAR2);
    @(posedge trn_clk); #1;
    trn_rsrc_rdy_n = 1'b1;
    reset_n = 1'b0;
    @(posedge trn_clk); #1;
    reset_n = 1'b1;
    rx_beat({32'h0000_0028, 32'h0}, 1'b0, 1'b1, BAR2);
    rx_idle();
    repeat (15) @(negedge trn_clk);
    check("t8_partial_drop", 64'(cap_q.size()), 64'(base));
    check("t8_req", 64'(cpl_req), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
